switch_debounce: RTL and testbench
==================================

Name: switch_debounce

Overview:
- Input-side conditioner for the board's 6 slide switches; it is the reader of the switch bank.
- Synchronises the raw switch vector to clk and debounces it as a whole vector.
- Publishes a stable copy, one-cycle change/rise/fall strobes and a wrapping change counter.
- Sits between the switch pins and any consumer logic (LED drivers, counters) so that logic never sees bounce or metastability.

Parameters:
- WIDTH, 6, number of switch bits.
- DEBOUNCE_CYCLES, 1000000, consecutive cycles the synchronised value must hold before acceptance (10 ms at 100 MHz); minimum 1.
- COUNT_W, 8, width of change_count.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- switch  input  WIDTH  raw asynchronous switch pins
- switch_stable  output  WIDTH  debounced switch value
- change  output  1  one-cycle pulse when switch_stable updates
- rise  output  WIDTH  one-cycle per-bit 0->1 strobes, aligned with change
- fall  output  WIDTH  one-cycle per-bit 1->0 strobes, aligned with change
- change_count  output  COUNT_W  number of accepted updates, wraps

Behaviour:
- Reset: all registers are cleared when reset is high at a rising edge. This covers sync stages, candidate, counter, switch_stable, change, rise, fall and change_count.
- Reset is sampled only at the edge. Reset overrides everything, including mid-count, and the count restarts from zero.
- Synchroniser: two flops, s1 <= switch, s2 <= s1. s2 is the only internal use of switch.
- Candidate register cand and counter cnt, width clog2(DEBOUNCE_CYCLES+1). Each edge:
  - If s2 != cand: cand <= s2, cnt <= 0. Any bounce restarts the qualification.
  - Else if cand != switch_stable:
    - If cnt == DEBOUNCE_CYCLES-1: switch_stable <= cand, cnt <= 0, and the strobes are registered for the next cycle.
    - Otherwise cnt <= cnt+1.
  - Else cnt <= 0.
- Strobes are registered:
  - change is 1 for exactly the cycle in which the new switch_stable is first visible.
  - rise = cand & ~old_stable, fall = ~cand & old_stable.
  - All strobes are 0 in every other cycle.
- Latency: with switch changed before edge 1 and held, switch_stable and change update at edge DEBOUNCE_CYCLES+3.
- Multi-bit changes:
  - Bits changing on different edges each restart the qualification.
  - The final settled vector is accepted in a single update, with a single change pulse.
- Glitches: a pulse on switch shorter than DEBOUNCE_CYCLES cycles (after sync) produces no update and no strobe.
- A change back to the current switch_stable value before acceptance cancels the pending update silently.
- change_count increments by 1 on each accepted update and wraps 2^COUNT_W-1 -> 0 with no flag.
- Post-reset: switch_stable is 0 regardless of pins. Non-zero pins held through reset release are qualified normally and produce one change pulse.

Decomposition:
- Shared package: DEBOUNCE_CYCLES default, SW_WIDTH = 6, and a clog2 helper function for cnt width.
- Sub-module sync2 (parameterised WIDTH, two-flop synchroniser with synchronous reset). It is reusable for buttons.
- Debounce FSM/counter and strobe logic stay in switch_debounce.

Test Plan:
All scenarios use DEBOUNCE_CYCLES = 4.
1. Reset check: reset high 3 cycles with switch=6'b111111 -> switch_stable=0, change=0, rise=0, fall=0, change_count=0 throughout reset.
2. Clean step: switch 0 -> 6'b000101 held -> at edge 7 switch_stable=6'b000101, change=1 for one cycle, rise=6'b000101, fall=0, change_count=1.
3. Bounce: switch toggles 0/6'b000001 every 2 cycles for 20 cycles, then holds 6'b000001 -> no change during bouncing; single update 7 edges after the last toggle, change_count +1.
4. Short glitch: switch=6'b100000 for 3 cycles, then back to stable value -> no change pulse, switch_stable unchanged.
5. Falling/mixed: stable 6'b110000 -> switch 6'b011000 -> one update with rise=6'b001000 and fall=6'b100000.
6. Wrap and reset mid-operation:
   - 256 accepted updates -> change_count reads 0 after the 256th.
   - Reset asserted 2 cycles into qualification -> no change pulse; outputs 0; re-qualification starts after release.

Source files
------------

// File: rtl/switch_debounce_pkg.sv
// Shared constants and helpers for the switch conditioning path.
// Provides default widths/timing and a clog2 used for counter sizing.
package switch_debounce_pkg;

  localparam int SW_WIDTH            = 6;
  localparam int DEBOUNCE_CYCLES_DEF = 1000000;

  // Bits needed to hold values 0..v-1, never less than 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/switch_debounce_sync2.sv
// Two-flop synchroniser for asynchronous level inputs (switches, buttons).
// Ports: clk, reset (sync, high), d (async in), q (synchronised out).
module switch_debounce_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/switch_debounce.sv
// Whole-vector switch debouncer with change/rise/fall strobes and count.
// Ports: clk, reset, switch in; switch_stable, change, rise, fall, change_count.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int COUNT_W         = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   switch,
  output logic [WIDTH-1:0]   switch_stable,
  output logic               change,
  output logic [WIDTH-1:0]   rise,
  output logic [WIDTH-1:0]   fall,
  output logic [COUNT_W-1:0] change_count
);

  localparam int CNT_W = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] cand;
  logic [CNT_W-1:0] cnt;

  switch_debounce_sync2 #(
    .WIDTH(WIDTH)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (switch),
    .q    (s2)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cand          <= '0;
      cnt           <= '0;
      switch_stable <= '0;
      change        <= 1'b0;
      rise          <= '0;
      fall          <= '0;
      change_count  <= '0;
    end else begin
      change <= 1'b0;
      rise   <= '0;
      fall   <= '0;
      if (s2 != cand) begin
        // Any movement of the synchronised vector restarts qualification.
        cand <= s2;
        cnt  <= '0;
      end else if (cand != switch_stable) begin
        if (cnt == LAST) begin
          switch_stable <= cand;
          cnt           <= '0;
          change        <= 1'b1;
          rise          <= cand & ~switch_stable;
          fall          <= ~cand & switch_stable;
          change_count  <= change_count + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_switch_debounce.sv
// Self-checking bench for switch_debounce with a run-length reference model.
// Drives directed scenarios plus random hold-time stimulus.
module tb_switch_debounce;

  localparam int D = 4;
  localparam int W = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] switch = '0;
  logic [W-1:0] switch_stable;
  logic         change;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic [7:0]   change_count;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the switch value seen by the qualifier lags the pins
  // by two edges; a value is accepted once it has been seen on D+1
  // consecutive edges and differs from the published value.
  logic [W-1:0] d1, d2, prev;
  int           run;
  logic [W-1:0] m_stable, m_rise, m_fall;
  logic         m_change;
  logic [7:0]   m_count;

  always #5 clk = ~clk;

  switch_debounce #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D),
    .COUNT_W(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .switch       (switch),
    .switch_stable(switch_stable),
    .change       (change),
    .rise         (rise),
    .fall         (fall),
    .change_count (change_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rst, input logic [W-1:0] sw);
    logic [W-1:0] x;
    m_change = 1'b0;
    m_rise   = '0;
    m_fall   = '0;
    if (rst) begin
      d1 = '0; d2 = '0; prev = '0; run = 0;
      m_stable = '0; m_count = '0;
    end else begin
      x  = d2;
      d2 = d1;
      d1 = sw;
      if (x == prev) run++;
      else begin
        run  = 1;
        prev = x;
      end
      if (x != m_stable && run == D + 1) begin
        m_rise   = x & ~m_stable;
        m_fall   = ~x & m_stable;
        m_stable = x;
        m_change = 1'b1;
        m_count  = m_count + 8'd1;
      end
    end
  endtask

  task automatic step(input logic rst, input logic [W-1:0] sw);
    reset  = rst;
    switch = sw;
    @(posedge clk);
    model_edge(rst, sw);
    #1;
    chk("stable", 32'(switch_stable), 32'(m_stable));
    chk("change", 32'(change), 32'(m_change));
    chk("rise",   32'(rise),   32'(m_rise));
    chk("fall",   32'(fall),   32'(m_fall));
    chk("count",  32'(change_count), 32'(m_count));
  endtask

  task automatic hold(input logic [W-1:0] sw, input int n);
    for (int i = 0; i < n; i++) step(1'b0, sw);
  endtask

  initial begin
    logic [W-1:0] v;
    logic [7:0]   c0;
    int           len;

    d1 = '0; d2 = '0; prev = '0; run = 0;
    m_stable = '0; m_count = '0;
    m_change = 1'b0; m_rise = '0; m_fall = '0;

    // Reset with all pins high
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 6'b111111);
      chk("rst_stable", 32'(switch_stable), 32'd0);
      chk("rst_count",  32'(change_count), 32'd0);
      chk("rst_change", 32'(change), 32'd0);
    end
    // Pins high through release qualify normally
    hold(6'b111111, 10);
    chk("post_rst_stable", 32'(switch_stable), 32'h3f);
    chk("post_rst_count",  32'(change_count), 32'd1);

    // Clean step, latency D+3
    step(1'b1, '0);
    hold('0, 4);
    for (int e = 1; e <= 8; e++) begin
      step(1'b0, 6'b000101);
      if (e == 6) chk("step_e6", 32'(change), 32'd0);
      if (e == 7) begin
        chk("step_e7_chg",  32'(change), 32'd1);
        chk("step_e7_stb",  32'(switch_stable), 32'h05);
        chk("step_e7_rise", 32'(rise), 32'h05);
        chk("step_e7_cnt",  32'(change_count), 32'd1);
      end
      if (e == 8) chk("step_e8_chg", 32'(change), 32'd0);
    end

    // Bounce then settle
    hold('0, 10);
    c0 = change_count;
    for (int i = 0; i < 10; i++) hold(i[0] ? 6'b000000 : 6'b000001, 2);
    hold(6'b000001, 10);
    chk("bounce_count", 32'(change_count), 32'(c0 + 8'd1));
    chk("bounce_stable", 32'(switch_stable), 32'h01);

    // Short glitch
    c0 = change_count;
    hold(6'b100000, 3);
    hold(6'b000001, 10);
    chk("glitch_count", 32'(change_count), 32'(c0));

    // Mixed rise/fall
    hold(6'b110000, 10);
    for (int e = 1; e <= 8; e++) begin
      step(1'b0, 6'b011000);
      if (e == 7) begin
        chk("mixed_rise", 32'(rise), 32'h08);
        chk("mixed_fall", 32'(fall), 32'h20);
      end
    end

    // 256 updates wrap the counter
    c0 = change_count;
    for (int i = 0; i < 256; i++) hold(i[0] ? 6'b011000 : 6'b000111, 7);
    chk("wrap_count", 32'(change_count), 32'(c0));

    // Reset two cycles into qualification
    hold(6'b101010, 3);
    hold(6'b010101, 4);
    step(1'b1, 6'b010101);
    chk("midrst_stable", 32'(switch_stable), 32'd0);
    chk("midrst_count",  32'(change_count), 32'd0);
    hold(6'b010101, 8);
    chk("requal_stable", 32'(switch_stable), 32'h15);

    // Random hold lengths around the threshold
    for (int i = 0; i < 300; i++) begin
      v   = W'($urandom);
      len = $urandom_range(1, 9);
      hold(v, len);
      if ($urandom_range(0, 60) == 0) step(1'b1, v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
